// File: rtl/filt_cic_comp.sv
// ---------------------------------------------------------------------------
// filt_cic_comp
// Decimate-by-2 droop-compensation FIR that sits right after the CIC
// decimator. Every accepted sample lands in a circular buffer; every second
// accepted sample (the "trigger" sample) launches a serial MAC over all taps,
// after which the result is rounded, saturated and strobed out.
//
// Ports
//   i_clk      clock
//   i_rst      asynchronous active-high reset
//   i_valid    input sample strobe
//   i_data     signed input sample (CIC output)
//   o_valid    one-cycle output strobe
//   o_data     signed output, held until the next o_valid
//   o_busy     high while the MAC / output stage is running
//   o_overrun  sticky flag, set when an input sample had to be dropped
// ---------------------------------------------------------------------------
module filt_cic_comp #(
    parameter int gp_inp_width  = 14,
    parameter int gp_oup_width  = 16,
    parameter int gp_coef_width = 8,
    parameter int gp_nr_taps    = 5,
    parameter logic [gp_nr_taps*gp_coef_width-1:0] gp_coeffs = 40'h0102030201,
    parameter int gp_shift      = 0,
    parameter int gp_phase      = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    input  logic signed [gp_inp_width-1:0] i_data,
    output logic                           o_valid,
    output logic signed [gp_oup_width-1:0] o_data,
    output logic                           o_busy,
    output logic                           o_overrun
);

    localparam int PRW = gp_inp_width + gp_coef_width;
    localparam int AW  = PRW + $clog2(gp_nr_taps);
    localparam int PW  = $clog2(gp_nr_taps);
    // Post-processing width: room for the rounding add and for a direct
    // signed compare against the output limits.
    localparam int EW  = (AW + 1 > gp_oup_width) ? AW + 1 : gp_oup_width + 1;
    localparam int RS  = (gp_shift > 0) ? gp_shift - 1 : 0;
    localparam logic [PW-1:0] LAST = PW'(gp_nr_taps - 1);
    localparam logic signed [EW-1:0] OMAX =
        {{(EW-gp_oup_width+1){1'b0}}, {(gp_oup_width-1){1'b1}}};
    localparam logic signed [EW-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                          state_q, state_d;
    logic signed [gp_inp_width-1:0]  buf_q [gp_nr_taps];
    logic [PW-1:0]                   wptr_q;   // oldest entry = next write slot
    logic [PW-1:0]                   rd_q;     // buffer slot holding x[k]
    logic [PW-1:0]                   k_q;
    logic                            phase_q;
    logic                            pend_vld_q, pend_vld_d;
    logic signed [gp_inp_width-1:0]  pend_data_q, pend_data_d;
    logic signed [AW-1:0]            acc_q, acc_d;
    logic                            ovr_q, ovr_d;
    logic                            o_valid_q;
    logic signed [gp_oup_width-1:0]  o_data_q, o_data_d;

    logic                            wen, trig;
    logic signed [gp_inp_width-1:0]  wdata;
    logic signed [gp_coef_width-1:0] coef;
    logic signed [gp_inp_width-1:0]  xk;
    logic signed [PRW-1:0]           prod;
    logic signed [EW-1:0]            acc_x, rnd, shr;

    // Control: buffer writes, pending register, overrun and next state.
    // A pending sample is committed on the first IDLE cycle; a sample that
    // arrives in that same cycle refills the pending register.
    always_comb begin
        state_d     = state_q;
        wen         = 1'b0;
        wdata       = i_data;
        trig        = 1'b0;
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        ovr_d       = ovr_q;
        case (state_q)
            S_IDLE: begin
                if (pend_vld_q) begin
                    wen        = 1'b1;
                    wdata      = pend_data_q;
                    pend_vld_d = i_valid;
                    if (i_valid) pend_data_d = i_data;
                end else if (i_valid) begin
                    wen = 1'b1;
                end
                trig = wen && (phase_q == 1'(gp_phase));
                if (trig) state_d = S_MAC;
            end
            S_MAC: begin
                if (k_q == LAST) state_d = S_OUT;
                if (i_valid) begin
                    if (!pend_vld_q) begin
                        pend_vld_d  = 1'b1;
                        pend_data_d = i_data;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                if (i_valid) begin
                    if (!pend_vld_q) begin
                        pend_vld_d  = 1'b1;
                        pend_data_d = i_data;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Datapath: one product per cycle, then round-half-up and saturate.
    always_comb begin
        coef  = gp_coeffs[int'(k_q)*gp_coef_width +: gp_coef_width];
        xk    = buf_q[rd_q];
        prod  = coef * xk;
        acc_d = acc_q + {{(AW-PRW){prod[PRW-1]}}, prod};
        acc_x = {{(EW-AW){acc_q[AW-1]}}, acc_q};
        rnd   = (gp_shift > 0) ? (EW'(1) << RS) : '0;
        shr   = (acc_x + rnd) >>> gp_shift;
        if (shr > OMAX)      o_data_d = OMAX[gp_oup_width-1:0];
        else if (shr < OMIN) o_data_d = OMIN[gp_oup_width-1:0];
        else                 o_data_d = shr[gp_oup_width-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < gp_nr_taps; i++) buf_q[i] <= '0;
            wptr_q      <= '0;
            rd_q        <= '0;
            k_q         <= '0;
            phase_q     <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
            acc_q       <= '0;
            ovr_q       <= 1'b0;
            o_valid_q   <= 1'b0;
            o_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            ovr_q       <= ovr_d;
            o_valid_q   <= 1'b0;
            if (wen) begin
                buf_q[wptr_q] <= wdata;
                wptr_q        <= (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
                phase_q       <= ~phase_q;
            end
            case (state_q)
                S_IDLE: if (trig) begin
                    acc_q <= '0;
                    k_q   <= '0;
                    rd_q  <= wptr_q;  // slot being written now = newest sample
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 1'b1;
                    rd_q  <= (rd_q == '0) ? LAST : rd_q - 1'b1;  // walk toward older samples
                end
                default: begin
                    o_valid_q <= 1'b1;
                    o_data_q  <= o_data_d;
                end
            endcase
        end
    end

    assign o_valid   = o_valid_q;
    assign o_data    = o_data_q;
    assign o_busy    = (state_q != S_IDLE);
    assign o_overrun = ovr_q;

endmodule

// File: tb/tb_filt_cic_comp.sv
module tb_filt_cic_comp;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               vld = 1'b0;
    logic signed [13:0] d14 = '0;
    logic signed [15:0] d16 = '0;
    logic [2:0]         ov, bz, ovr;
    logic signed [15:0] od [3];

    always #5 clk = ~clk;

    // dut0: defaults, dut1: gp_shift=2, dut2: 16-bit input (saturation)
    filt_cic_comp dut0 (.i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(d14),
        .o_valid(ov[0]), .o_data(od[0]), .o_busy(bz[0]), .o_overrun(ovr[0]));
    filt_cic_comp #(.gp_shift(2)) dut1 (.i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(d14),
        .o_valid(ov[1]), .o_data(od[1]), .o_busy(bz[1]), .o_overrun(ovr[1]));
    filt_cic_comp #(.gp_inp_width(16)) dut2 (.i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(d16),
        .o_valid(ov[2]), .o_data(od[2]), .o_busy(bz[2]), .o_overrun(ovr[2]));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    // ---------------- reference model ----------------
    localparam logic [39:0] COEF = 40'h0102030201;
    int     SH [3] = '{0, 2, 0};
    int     hq14[$], hq16[$];
    int     nacc = 0;
    longint eq  [3][$];
    int     obs [3][$];
    int     first0 = -1;

    function automatic longint model(input int hist[$], input int shift);
        logic [39:0] c = COEF;
        longint acc = 0;
        for (int k = 0; k < 5; k++) begin
            int idx = hist.size() - 1 - k;
            if (idx >= 0) acc += longint'($signed(c[k*8 +: 8])) * hist[idx];
        end
        if (shift > 0) acc = (acc + (longint'(1) << (shift - 1))) >>> shift;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic push(input int a14, input int a16);
        hq14.push_back(a14);
        hq16.push_back(a16);
        if (nacc % 2 == 0) begin
            eq[0].push_back(model(hq14, SH[0]));
            eq[1].push_back(model(hq14, SH[1]));
            eq[2].push_back(model(hq16, SH[2]));
        end
        nacc++;
    endtask

    task automatic clear_model();
        hq14.delete(); hq16.delete(); nacc = 0;
        for (int i = 0; i < 3; i++) eq[i].delete();
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 3; i++) obs[i].delete();
    endtask

    task automatic chk(input string tag, input logic signed [63:0] o, input logic signed [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s obs %0d exp %0d", tag, o, e);
        end
    endtask

    // Every output strobe is compared against the model's next expectation.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (ov[i]) begin
                    obs[i].push_back(int'(od[i]));
                    if (i == 0 && first0 < 0) first0 = cyc;
                    if (eq[i].size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL extra_out%0d obs %0d exp none", i, od[i]);
                    end else begin
                        chk($sformatf("out%0d", i), od[i], eq[i].pop_front());
                    end
                end
            end
        end
    end

    // All tasks start and end at #1 after a rising edge.
    task automatic send(input int v14, input int v16, input int gap);
        vld = 1'b1; d14 = 14'(v14); d16 = 16'(v16);
        @(posedge clk); #1;
        vld = 1'b0;
        push(v14, v16);
        repeat (gap - 1) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_obs(input string tag, input int i, input int k, input int e);
        chk($sformatf("%s_n", tag), (obs[i].size() > k), 1);
        if (obs[i].size() > k) chk($sformatf("%s_%0d", tag, k), obs[i][k], e);
    endtask

    task automatic chk_drained(input string tag);
        for (int i = 0; i < 3; i++) chk($sformatf("%s_pending%0d", tag, i), eq[i].size(), 0);
    endtask

    int tstart;
    int e_imp0 [5] = '{1, 3, 1, 0, 0};
    int e_imp1 [5] = '{0, 1, 0, 0, 0};
    int e_dc0  [4] = '{300, 800, 900, 900};
    int e_dc1  [4] = '{75, 200, 225, 225};
    int e_i2   [5] = '{1, 2, 1, 0, 0};

    initial begin
        // reset values
        #1; @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid%0d", i), ov[i], 0);
            chk($sformatf("rst_data%0d", i), od[i], 0);
            chk($sformatf("rst_busy%0d", i), bz[i], 0);
            chk($sformatf("rst_ovr%0d", i), ovr[i], 0);
        end
        do_reset();

        // impulse 1, then DC 100 straight after
        clear_obs(); first0 = -1; tstart = cyc;
        send(1, 1, 10);
        for (int n = 0; n < 8; n++) send(0, 0, 10);
        chk("latency", first0 - tstart, 7);
        for (int k = 0; k < 5; k++) chk_obs("imp0", 0, k, e_imp0[k]);
        for (int k = 0; k < 5; k++) chk_obs("imp1", 1, k, e_imp1[k]);
        clear_obs();
        for (int n = 0; n < 8; n++) send(100, 100, 10);
        for (int k = 0; k < 4; k++) chk_obs("dc0", 0, k, e_dc0[k]);
        for (int k = 0; k < 4; k++) chk_obs("dc1", 1, k, e_dc1[k]);
        chk_drained("imp_dc");

        // impulse 2 on the rounding instance
        do_reset(); clear_obs();
        send(2, 2, 10);
        for (int n = 0; n < 8; n++) send(0, 0, 10);
        for (int k = 0; k < 5; k++) chk_obs("imp2", 1, k, e_i2[k]);

        // saturation
        do_reset(); clear_obs();
        for (int n = 0; n < 10; n++) send(8191, 32767, 8);
        for (int k = 0; k < 5; k++) chk_obs("satp", 2, k, 32767);
        clear_obs();
        for (int n = 0; n < 10; n++) send(-8192, -32768, 8);
        chk_obs("satn", 2, 3, -32768);
        chk_obs("satn", 2, 4, -32768);
        chk_obs("satn0", 0, 4, -32768);
        chk_drained("sat");

        // overrun: A triggers, B goes pending, C is dropped
        do_reset(); clear_obs();
        vld = 1'b1; d14 = 14'sd5; d16 = 16'sd5;
        @(posedge clk); #1; vld = 1'b0; push(5, 5);
        @(posedge clk); #1;
        chk("busy_mac", bz[0], 1);
        vld = 1'b1; d14 = 14'sd7; d16 = 16'sd7;
        @(posedge clk); #1;
        chk("ovr_before", ovr[0], 0);
        d14 = 14'sd100; d16 = 16'sd100;
        @(posedge clk); #1; vld = 1'b0; push(7, 7);
        for (int i = 0; i < 3; i++) chk($sformatf("ovr_set%0d", i), ovr[i], 1);
        repeat (10) begin @(posedge clk); #1; end
        chk("ovr_sticky", ovr[0], 1);
        chk("ovr_nout1", obs[0].size(), 1);
        send(3, 3, 10);
        chk("ovr_nout2", obs[0].size(), 2);
        chk_obs("ovr_a", 0, 0, 5);
        chk_obs("ovr_d", 0, 1, 32);
        chk("ovr_sticky2", ovr[1], 1);
        chk_drained("ovr");

        // reset three cycles into the MAC
        do_reset(); clear_obs();
        vld = 1'b1; d14 = 14'sd1; d16 = 16'sd1;
        @(posedge clk); #1; vld = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_busy", bz[0], 1);
        rst = 1'b1; clear_model(); #1;
        chk("mid_busy_rst", bz[0], 0);
        chk("mid_data_rst", od[0], 0);
        vld = 1'b1; d14 = 14'sd9; d16 = 16'sd9;
        repeat (3) begin @(posedge clk); #1; end
        vld = 1'b0;
        chk("mid_valid_rst", ov[0], 0);
        rst = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("mid_no_out", obs[0].size(), 0);
        chk("mid_data_idle", od[0], 0);
        for (int n = 0; n < 5; n++) send((n == 0) ? 1 : 0, (n == 0) ? 1 : 0, 10);
        for (int k = 0; k < 3; k++) chk_obs("replay", 0, k, e_imp0[k]);

        // randomized traffic against the model
        for (int n = 0; n < 40; n++)
            send(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(7, 12)));
        repeat (20) begin @(posedge clk); #1; end
        chk_drained("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
